// File: rtl/decode_writeback.sv
// Y86-64 SEQ register file: decode-side operand reads, writeback-side commits,
// halt latch and retired-instruction counter.
module decode_writeback #(
    parameter logic [63:0] STACK_INIT = 64'h200,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       opcode,
    input  logic [7:0]       rArB,
    input  logic             Cnd,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    input  logic             wb_en,
    output logic [63:0]      valA,
    output logic [63:0]      valB,
    output logic             halted,
    output logic [CNT_W-1:0] retire_cnt,
    input  logic [3:0]       dbg_reg,
    output logic [63:0]      dbg_val
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 15;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    logic [XLEN-1:0] regs [NREG];

    logic [3:0] icode;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       commit;

    assign icode  = opcode[7:4];
    assign r_a    = rArB[7:4];
    assign r_b    = rArB[3:0];
    assign commit = wb_en & ~halted;

    // Source and destination register selection from icode
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            I_RRMOV: begin
                src_a = r_a;
                dst_e = Cnd ? r_b : RNONE;
            end
            I_IRMOV: dst_e = r_b;
            I_RMMOV: begin
                src_a = r_a;
                src_b = r_b;
            end
            I_MRMOV: begin
                src_b = r_b;
                dst_m = r_a;
            end
            I_OPQ: begin
                src_a = r_a;
                src_b = r_b;
                dst_e = r_b;
            end
            I_CALL: begin
                src_b = RSP;
                dst_e = RSP;
            end
            I_RET: begin
                src_a = RSP;
                src_b = RSP;
                dst_e = RSP;
            end
            I_PUSH: begin
                src_a = r_a;
                src_b = RSP;
                dst_e = RSP;
            end
            I_POP: begin
                src_a = RSP;
                src_b = RSP;
                dst_e = RSP;
                dst_m = r_a;
            end
            default: ;
        endcase
    end

    // Read ports see pre-edge state; index F reads as zero
    assign valA    = (src_a == RNONE)   ? '0 : regs[src_a];
    assign valB    = (src_b == RNONE)   ? '0 : regs[src_b];
    assign dbg_val = (dbg_reg == RNONE) ? '0 : regs[dbg_reg];

    // Writeback: valM takes priority over valE on the same destination
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (4'(i) == RSP) ? STACK_INIT : '0;
            end
            halted     <= 1'b0;
            retire_cnt <= '0;
        end else if (commit) begin
            for (int i = 0; i < NREG; i++) begin
                if (dst_m == 4'(i)) begin
                    regs[i] <= valM;
                end else if (dst_e == 4'(i)) begin
                    regs[i] <= valE;
                end
            end
            if (icode == I_HALT) begin
                halted <= 1'b1;
            end
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: architectural model checked every cycle
// plus literal expectations from hand-traced programs.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  opcode;
    logic [7:0]  rArB;
    logic        Cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        wb_en;
    logic [63:0] valA;
    logic [63:0] valB;
    logic        halted;
    logic [31:0] retire_cnt;
    logic [3:0]  dbg_reg;
    logic [63:0] dbg_val;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    decode_writeback #(.STACK_INIT(64'h200), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .rArB(rArB), .Cnd(Cnd),
        .valE(valE), .valM(valM), .wb_en(wb_en), .valA(valA), .valB(valB),
        .halted(halted), .retire_cnt(retire_cnt), .dbg_reg(dbg_reg), .dbg_val(dbg_val)
    );

    always #5 clk = ~clk;

    // Architectural model
    logic [63:0] m_reg [15];
    bit          m_halt;
    logic [31:0] m_cnt;

    function automatic logic [3:0] f_src_a(input logic [7:0] op, input logic [7:0] ab);
        case (op[7:4])
            4'h2, 4'h4, 4'h6, 4'hA: return ab[7:4];
            4'h9, 4'hB:             return 4'h4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] f_src_b(input logic [7:0] op, input logic [7:0] ab);
        case (op[7:4])
            4'h4, 4'h5, 4'h6:       return ab[3:0];
            4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] f_dst_e(input logic [7:0] op, input logic [7:0] ab, input logic c);
        case (op[7:4])
            4'h2:                   return c ? ab[3:0] : 4'hF;
            4'h3, 4'h6:             return ab[3:0];
            4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] f_dst_m(input logic [7:0] op, input logic [7:0] ab);
        case (op[7:4])
            4'h5, 4'hB: return ab[7:4];
            default:    return 4'hF;
        endcase
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] idx);
        return (idx == 4'hF) ? 64'd0 : m_reg[idx];
    endfunction

    always @(posedge clk) begin
        logic [3:0] de;
        logic [3:0] dm;
        if (rst) begin
            for (int i = 0; i < 15; i++) m_reg[i] = 64'd0;
            m_reg[4] = 64'h200;
            m_halt   = 1'b0;
            m_cnt    = 32'd0;
        end else if (wb_en && !m_halt) begin
            de = f_dst_e(opcode, rArB, Cnd);
            dm = f_dst_m(opcode, rArB);
            if (de != 4'hF) m_reg[de] = valE;
            if (dm != 4'hF) m_reg[dm] = valM;
            if (opcode[7:4] == 4'h0) m_halt = 1'b1;
            m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model valA", valA, m_read(f_src_a(opcode, rArB)));
            chk("model valB", valB, m_read(f_src_b(opcode, rArB)));
            chk("model halted", 64'(halted), 64'(m_halt));
            chk("model retire_cnt", 64'(retire_cnt), 64'(m_cnt));
            chk("model dbg_val", dbg_val, m_read(dbg_reg));
        end
    end

    task automatic drive(input logic [7:0] op, input logic [7:0] ab, input logic c,
                         input logic [63:0] ve, input logic [63:0] vm, input logic we,
                         input logic r, input logic [3:0] dbg);
        opcode = op; rArB = ab; Cnd = c; valE = ve; valM = vm;
        wb_en = we; rst = r; dbg_reg = dbg;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [7:0] op, input logic [7:0] ab, input logic [3:0] dbg);
        drive(op, ab, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, dbg);
        #1;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  ab;
        logic        c;
        logic [63:0] ve;
        logic [63:0] vm;
    } vec_t;

    vec_t tbl [8];

    initial begin
        drive(8'h10, 8'hFF, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 4'h4);
        step();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        idle(8'h10, 8'hFF, 4'h4);
        chk("reset reg4", dbg_val, 64'h200);
        idle(8'h10, 8'hFF, 4'h0);
        chk("reset reg0", dbg_val, 64'd0);
        chk("reset halted", 64'(halted), 64'd0);
        chk("reset cnt", 64'(retire_cnt), 64'd0);
        idle(8'h10, 8'hFF, 4'hF);
        chk("dbg F", dbg_val, 64'd0);

        // irmovq $100, %rdx
        drive(8'h30, 8'hF2, 1'b0, 64'd100, 64'd0, 1'b1, 1'b0, 4'h2);
        #1 chk("irmov pre-edge reg2", dbg_val, 64'd0);
        step();
        idle(8'h60, 8'h20, 4'h2);
        chk("irmov reg2", dbg_val, 64'd100);
        chk("irmov cnt", 64'(retire_cnt), 64'd1);
        chk("opq valA", valA, 64'd100);
        chk("opq valB", valB, 64'd0);

        // cmovXX, condition false then true
        drive(8'h21, 8'h23, 1'b0, 64'd55, 64'd0, 1'b1, 1'b0, 4'h3);
        step();
        idle(8'h10, 8'hFF, 4'h3);
        chk("cmov cnd0 reg3", dbg_val, 64'd0);
        chk("cmov cnd0 cnt", 64'(retire_cnt), 64'd2);
        drive(8'h21, 8'h23, 1'b1, 64'd55, 64'd0, 1'b1, 1'b0, 4'h3);
        step();
        idle(8'h10, 8'hFF, 4'h3);
        chk("cmov cnd1 reg3", dbg_val, 64'd55);

        // popq %rsp: valM wins over valE
        drive(8'hB0, 8'h4F, 1'b0, 64'h208, 64'hABCD, 1'b1, 1'b0, 4'h4);
        #1;
        chk("popq pre valA", valA, 64'h200);
        chk("popq pre valB", valB, 64'h200);
        step();
        idle(8'h10, 8'hFF, 4'h4);
        chk("popq reg4", dbg_val, 64'hABCD);
        chk("popq cnt", 64'(retire_cnt), 64'd4);

        // Illegal icode retires without writes
        drive(8'hC0, 8'h00, 1'b1, 64'hDEAD, 64'hBEEF, 1'b1, 1'b0, 4'h0);
        step();
        idle(8'h10, 8'hFF, 4'h0);
        chk("illegal reg0", dbg_val, 64'd0);
        chk("illegal cnt", 64'(retire_cnt), 64'd5);
        chk("illegal halted", 64'(halted), 64'd0);

        // Mixed directed program, checked by the model each cycle
        tbl[0] = '{8'h30, 8'hF7, 1'b0, 64'h1111, 64'h0};
        tbl[1] = '{8'h60, 8'h72, 1'b0, 64'h2222, 64'h0};
        tbl[2] = '{8'h50, 8'h87, 1'b0, 64'h0, 64'h3333};
        tbl[3] = '{8'h40, 8'h78, 1'b0, 64'h4444, 64'h5555};
        tbl[4] = '{8'h80, 8'hFF, 1'b0, 64'h1F0, 64'h0};
        tbl[5] = '{8'h90, 8'hFF, 1'b0, 64'h1F8, 64'h6666};
        tbl[6] = '{8'h20, 8'h8E, 1'b1, 64'h7777, 64'h0};
        tbl[7] = '{8'h70, 8'hFF, 1'b1, 64'h8888, 64'h9999};
        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].op, tbl[k].ab, tbl[k].c, tbl[k].ve, tbl[k].vm, 1'b1, 1'b0, 4'(k + 2));
            step();
        end
        idle(8'h10, 8'hFF, 4'hE);
        chk("table reg14", dbg_val, 64'h7777);
        idle(8'h10, 8'hFF, 4'h8);
        chk("table reg8", dbg_val, 64'h3333);

        // pushq then halt, from a fresh reset
        drive(8'h10, 8'hFF, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 4'h4);
        step();
        drive(8'hA0, 8'h1F, 1'b0, 64'h1F8, 64'd0, 1'b1, 1'b0, 4'h4);
        step();
        idle(8'h10, 8'hFF, 4'h4);
        chk("pushq reg4", dbg_val, 64'h1F8);
        drive(8'h00, 8'hFF, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 4'h4);
        step();
        idle(8'h10, 8'hFF, 4'h4);
        chk("halt halted", 64'(halted), 64'd1);
        chk("halt cnt", 64'(retire_cnt), 64'd2);
        drive(8'h30, 8'hF5, 1'b0, 64'd7, 64'd0, 1'b1, 1'b0, 4'h5);
        step();
        step();
        idle(8'h10, 8'hFF, 4'h5);
        chk("halted reg5", dbg_val, 64'd0);
        chk("halted cnt", 64'(retire_cnt), 64'd2);
        chk("halted sticky", 64'(halted), 64'd1);

        // Reset overrides a simultaneous commit
        drive(8'h30, 8'hF6, 1'b0, 64'd9, 64'd0, 1'b1, 1'b1, 4'h6);
        step();
        idle(8'h10, 8'hFF, 4'h6);
        chk("midrst reg6", dbg_val, 64'd0);
        idle(8'h10, 8'hFF, 4'h4);
        chk("midrst reg4", dbg_val, 64'h200);
        chk("midrst halted", 64'(halted), 64'd0);
        chk("midrst cnt", 64'(retire_cnt), 64'd0);

        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
